// File: rtl/packet_check.sv
// packet_check: parses packet_gen test packets, checks header and payload, and emits one
// latency record or one error code per packet. Define PACKET_CHECK_PAYLOAD_EN to verify payload words.

module port_to_mac (
  input  logic [1:0]  port_i,
  output logic [47:0] mac_o
);
  // Locally administered base address; the port number occupies the two low bits.
  localparam logic [47:0] MAC_BASE = 48'h02_00_5E_10_00_00;
  assign mac_o = MAC_BASE | {46'd0, port_i};
endmodule

module packet_check #(
  parameter int BLOCK_SIZE = 32,
  parameter int META_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           packet_in,
  input  logic                  packet_in_en,
  input  logic [21:0]           time_now,
  input  logic                  clear_stats,
  output logic [META_WIDTH-1:0] meta_out,
  output logic                  meta_out_en,
  output logic                  err_en,
  output logic [2:0]            err_code,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam logic [15:0] BLK     = 16'(BLOCK_SIZE);
  localparam logic [15:0] MAX_LEN = 16'(63 * BLOCK_SIZE);

  typedef enum logic [2:0] {
    H_LEN, H_DMAC, H_TSTART, H_TEND, H_SMAC_HI, H_SMAC_LO, PAYLOAD
  } state_t;

  state_t                state_q, state_d;
  logic [5:0]            lenBlocks_q, lenBlocks_d;
  logic [15:0]           macHi_q, macHi_d;
  logic [1:0]            dstPort_q, dstPort_d;
  logic [1:0]            srcPort_q, srcPort_d;
  logic [21:0]           startTime_q, startTime_d;
  logic [8:0]            payCnt_q, payCnt_d;
  logic [2:0]            errCode_q, errCode_d;
  logic [META_WIDTH-1:0] metaOut_q, metaOut_d;
  logic                  metaEn_q, metaEn_d;
  logic                  errEn_q, errEn_d;
  logic [2:0]            errCodeOut_q, errCodeOut_d;
  logic [CNT_WIDTH-1:0]  pktCnt_q, pktCnt_d;
  logic [CNT_WIDTH-1:0]  errCnt_q, errCnt_d;

  logic [47:0] portMac [4];
  logic [47:0] macFull;
  logic        macHit;
  logic [1:0]  macPort;
  logic [15:0] lenBytes;
  logic        lenBad;
  logic        payBad;
  logic        pktInc;
  logic        errInc;
  logic [21:0] latency;

  for (genvar g = 0; g < 4; g++) begin : gen_p2m
    port_to_mac u_p2m (.port_i(2'(g)), .mac_o(portMac[g]));
  end

  // The MAC high half shares one register: DMAC high is consumed before SMAC high is latched.
  assign macFull  = {macHi_q, packet_in};
  assign lenBytes = packet_in[31:16];
  assign lenBad   = ((lenBytes % BLK) != 16'd0) || (lenBytes == 16'd0) || (lenBytes > MAX_LEN);
  assign latency  = time_now - startTime_q;

`ifdef PACKET_CHECK_PAYLOAD_EN
  assign payBad = (packet_in != 32'hFFFF_FFFF);
`else
  assign payBad = 1'b0;
`endif

  always_comb begin
    macHit  = 1'b0;
    macPort = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (macFull == portMac[i]) begin
        macHit  = 1'b1;
        macPort = 2'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    lenBlocks_d  = lenBlocks_q;
    macHi_d      = macHi_q;
    dstPort_d    = dstPort_q;
    srcPort_d    = srcPort_q;
    startTime_d  = startTime_q;
    payCnt_d     = payCnt_q;
    errCode_d    = errCode_q;
    metaOut_d    = metaOut_q;
    metaEn_d     = 1'b0;
    errEn_d      = 1'b0;
    errCodeOut_d = errCodeOut_q;
    pktInc       = 1'b0;
    errInc       = 1'b0;
    if (packet_in_en) begin
      unique case (state_q)
        H_LEN: begin
          macHi_d     = packet_in[15:0];
          lenBlocks_d = packet_in[26:21];
          errCode_d   = 3'd0;
          if (lenBad) begin
            errEn_d      = 1'b1;
            errCodeOut_d = 3'd1;
            errInc       = 1'b1;
          end else begin
            state_d = H_DMAC;
          end
        end
        H_DMAC: begin
          dstPort_d = macPort;
          if (!macHit && errCode_q == 3'd0) errCode_d = 3'd2;
          state_d = H_TSTART;
        end
        H_TSTART: begin
          startTime_d = packet_in[21:0];
          if (packet_in[31:22] != 10'd0 && errCode_q == 3'd0) errCode_d = 3'd4;
          state_d = H_TEND;
        end
        H_TEND: state_d = H_SMAC_HI;
        H_SMAC_HI: begin
          macHi_d = packet_in[15:0];
          state_d = H_SMAC_LO;
        end
        H_SMAC_LO: begin
          srcPort_d = macPort;
          if (!macHit && errCode_q == 3'd0) errCode_d = 3'd3;
          payCnt_d = {lenBlocks_q, 3'b000} - 9'd7;
          state_d  = PAYLOAD;
        end
        PAYLOAD: begin
          if (payBad && errCode_q == 3'd0) errCode_d = 3'd5;
          payCnt_d = payCnt_q - 9'd1;
          // Last word: report whichever error stuck first, including one found on this word.
          if (payCnt_q == 9'd0) begin
            state_d = H_LEN;
            if (errCode_d != 3'd0) begin
              errEn_d      = 1'b1;
              errCodeOut_d = errCode_d;
              errInc       = 1'b1;
            end else begin
              metaEn_d  = 1'b1;
              metaOut_d = META_WIDTH'({srcPort_q, dstPort_q, lenBlocks_q, latency});
              pktInc    = 1'b1;
            end
          end
        end
        default: state_d = H_LEN;
      endcase
    end

    pktCnt_d = pktCnt_q;
    if (clear_stats) pktCnt_d = '0;
    else if (pktInc && pktCnt_q != '1) pktCnt_d = pktCnt_q + CNT_WIDTH'(1);
    errCnt_d = errCnt_q;
    if (clear_stats) errCnt_d = '0;
    else if (errInc && errCnt_q != '1) errCnt_d = errCnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= H_LEN;
      lenBlocks_q  <= '0;
      macHi_q      <= '0;
      dstPort_q    <= '0;
      srcPort_q    <= '0;
      startTime_q  <= '0;
      payCnt_q     <= '0;
      errCode_q    <= '0;
      metaOut_q    <= '0;
      metaEn_q     <= 1'b0;
      errEn_q      <= 1'b0;
      errCodeOut_q <= '0;
      pktCnt_q     <= '0;
      errCnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      lenBlocks_q  <= lenBlocks_d;
      macHi_q      <= macHi_d;
      dstPort_q    <= dstPort_d;
      srcPort_q    <= srcPort_d;
      startTime_q  <= startTime_d;
      payCnt_q     <= payCnt_d;
      errCode_q    <= errCode_d;
      metaOut_q    <= metaOut_d;
      metaEn_q     <= metaEn_d;
      errEn_q      <= errEn_d;
      errCodeOut_q <= errCodeOut_d;
      pktCnt_q     <= pktCnt_d;
      errCnt_q     <= errCnt_d;
    end
  end

  assign meta_out    = metaOut_q;
  assign meta_out_en = metaEn_q;
  assign err_en      = errEn_q;
  assign err_code    = errCodeOut_q;
  assign pkt_cnt     = pktCnt_q;
  assign err_cnt     = errCnt_q;

endmodule

// File: tb/tb_packet_check.sv
// Randomized and directed bench for packet_check; expected results are derived per packet
// from its fields and compared every cycle against the DUT pulses, record and counters.

module tb_packet_check;

  localparam logic [47:0] MAC_BASE = 48'h02005E100000;
  localparam logic [47:0] BAD_MAC  = 48'hDEAD_BEEF_0001;
`ifdef PACKET_CHECK_PAYLOAD_EN
  localparam bit PAY_CHECK = 1'b1;
`else
  localparam bit PAY_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] packet_in;
  logic        packet_in_en;
  logic [21:0] time_now;
  logic        clear_stats;
  logic [31:0] meta_out;
  logic        meta_out_en;
  logic        err_en;
  logic [2:0]  err_code;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  packet_check #(.BLOCK_SIZE(32), .META_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .packet_in(packet_in), .packet_in_en(packet_in_en),
    .time_now(time_now), .clear_stats(clear_stats), .meta_out(meta_out),
    .meta_out_en(meta_out_en), .err_en(err_en), .err_code(err_code),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  typedef struct {
    int          due;
    bit          isErr;
    logic [2:0]  code;
    logic [31:0] meta;
  } expRec_t;

  expRec_t     expQ[$];
  int          cyc = 0;
  logic        clrSeen, rstSeen;
  bit          started = 1'b0;
  int          compared = 0;
  int          mismatched = 0;
  int          modelPkt = 0, modelErr = 0;
  logic [31:0] modelMeta = '0;
  logic [31:0] lastMetaSeen = '0;
  logic [2:0]  lastErrSeen = '0;
  int          metaPulses = 0, errPulses = 0;
  logic [21:0] timeNow = '0;
  logic        clrReq = 1'b0, rstReq = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      if (mismatched <= 40) $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [47:0] macOf(input int p);
    return MAC_BASE + 48'(p);
  endfunction

  function automatic int macToPort(input logic [47:0] mac);
    for (int p = 0; p < 4; p++) if (mac == macOf(p)) return p;
    return -1;
  endfunction

  function automatic logic [31:0] sat(input int v);
    return (v > 65535) ? 32'd65535 : 32'(v);
  endfunction

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    clrSeen <= clear_stats;
    rstSeen <= reset;
  end

  // Single compare process: pulses, held record and both counters against the model.
  initial begin
    expRec_t rec;
    bit      dueNow;
    forever begin
      @(negedge clk);
      if (rstSeen === 1'b1) begin
        started   = 1'b1;
        modelPkt  = 0;
        modelErr  = 0;
        modelMeta = '0;
        expQ.delete();
      end else if (started) begin
        dueNow = (expQ.size() > 0) && (expQ[0].due == cyc);
        if (dueNow) begin
          rec = expQ.pop_front();
          if (rec.isErr) modelErr++;
          else begin
            modelPkt++;
            modelMeta = rec.meta;
          end
          checkOutput("meta_out_en at result", {31'd0, meta_out_en}, {31'd0, !rec.isErr});
          checkOutput("err_en at result", {31'd0, err_en}, {31'd0, rec.isErr});
          if (rec.isErr) checkOutput("err_code", {29'd0, err_code}, {29'd0, rec.code});
        end else begin
          checkOutput("meta_out_en idle", {31'd0, meta_out_en}, 32'd0);
          checkOutput("err_en idle", {31'd0, err_en}, 32'd0);
        end
        if (clrSeen === 1'b1) begin
          modelPkt = 0;
          modelErr = 0;
        end
        checkOutput("meta_out", meta_out, modelMeta);
        checkOutput("pkt_cnt", {16'd0, pkt_cnt}, sat(modelPkt));
        checkOutput("err_cnt", {16'd0, err_cnt}, sat(modelErr));
      end
      if (meta_out_en === 1'b1) begin
        lastMetaSeen = meta_out;
        metaPulses++;
      end
      if (err_en === 1'b1) begin
        lastErrSeen = err_code;
        errPulses++;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] word, input logic en);
    @(posedge clk);
    #1;
    timeNow      = timeNow + 22'd1;
    packet_in    = word;
    packet_in_en = en;
    time_now     = timeNow;
    clear_stats  = clrReq;
    reset        = rstReq;
    clrReq       = 1'b0;
    rstReq       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus($urandom, 1'b0);
  endtask

  task automatic sendPacket(input int lenBytes, input logic [47:0] dmac, input logic [47:0] smac,
                            input logic [21:0] startT, input logic [9:0] tsRes, input int badIdx,
                            input logic [31:0] badVal, input logic [21:0] endT, input int gapPct,
                            input int abortAt, input bit clrLast);
    logic [31:0] w[$];
    int          nWords, dPort, sPort;
    logic [2:0]  code;
    logic [21:0] lat;
    expRec_t     rec;
    w.push_back({lenBytes[15:0], dmac[47:32]});
    if ((lenBytes % 32) != 0 || lenBytes <= 0 || lenBytes > 63 * 32) begin
      applyStimulus(w[0], 1'b1);
      rec.due = cyc + 1; rec.isErr = 1'b1; rec.code = 3'd1; rec.meta = '0;
      expQ.push_back(rec);
      return;
    end
    nWords = lenBytes / 4;
    w.push_back(dmac[31:0]);
    w.push_back({tsRes, startT});
    w.push_back($urandom);
    w.push_back({16'h0000, smac[47:32]});
    w.push_back(smac[31:0]);
    for (int i = 6; i < nWords; i++) w.push_back((i == badIdx) ? badVal : 32'hFFFF_FFFF);
    dPort = macToPort(dmac);
    sPort = macToPort(smac);
    code  = 3'd0;
    if (dPort < 0) code = 3'd2;
    else if (tsRes != 10'd0) code = 3'd4;
    else if (sPort < 0) code = 3'd3;
    else if (PAY_CHECK) begin
      for (int i = 6; i < nWords; i++) if (w[i] != 32'hFFFF_FFFF) code = 3'd5;
    end
    for (int i = 0; i < nWords; i++) begin
      if (i == abortAt) begin
        rstReq = 1'b1;
        applyStimulus(w[i], 1'b1);
        return;
      end
      while (gapPct > 0 && $urandom_range(99, 0) < gapPct) applyStimulus($urandom, 1'b0);
      if (i == nWords - 1) begin
        timeNow = endT - 22'd1;
        clrReq  = clrLast;
      end
      applyStimulus(w[i], 1'b1);
    end
    lat = endT - startT;
    rec.due   = cyc + 1;
    rec.isErr = (code != 3'd0);
    rec.code  = code;
    rec.meta  = {sPort[1:0], dPort[1:0], lenBytes[10:5], lat};
    expQ.push_back(rec);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int mBefore, eBefore, blocks, len, nW, bIdx;
    logic [47:0] dm, sm;
    logic [9:0]  tr;
    reset = 1'b1; packet_in = '0; packet_in_en = 1'b0; time_now = '0; clear_stats = 1'b0;
    rstReq = 1'b1;
    applyStimulus('0, 1'b0);
    applyStimulus('0, 1'b0);
    @(negedge clk);
    checkOutput("reset meta_out", meta_out, 32'd0);
    checkOutput("reset meta_out_en", {31'd0, meta_out_en}, 32'd0);
    checkOutput("reset err_en", {31'd0, err_en}, 32'd0);
    checkOutput("reset err_code", {29'd0, err_code}, 32'd0);
    checkOutput("reset pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    checkOutput("reset err_cnt", {16'd0, err_cnt}, 32'd0);
    idle(2);

    $display("[TB] directed: 1-block packet, latency 150");
    sendPacket(32, macOf(2), macOf(1), 22'd100, 10'd0, -1, '0, 22'd250, 0, -1, 1'b0);
    idle(2);
    @(negedge clk);
    checkOutput("t1 meta literal", lastMetaSeen, {2'd1, 2'd2, 6'd1, 22'd150});
    checkOutput("t1 pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
    checkOutput("t1 meta pulses", 32'(metaPulses), 32'd1);

    $display("[TB] directed: 63-block packet with gaps and timer wrap");
    sendPacket(2016, macOf(3), macOf(0), 22'h3FFFF0, 10'd0, -1, '0, 22'h000010, 30, -1, 1'b0);
    idle(2);
    @(negedge clk);
    checkOutput("t2 latency", {10'd0, lastMetaSeen[21:0]}, 32'h20);
    checkOutput("t2 len_blocks", {26'd0, lastMetaSeen[27:22]}, 32'd63);
    checkOutput("t2 meta pulses", 32'(metaPulses), 32'd2);

    $display("[TB] directed: bad lengths then a good packet");
    sendPacket(40, macOf(0), macOf(0), 22'd5, 10'd0, -1, '0, 22'd9, 0, -1, 1'b0);
    idle(2);
    @(negedge clk);
    checkOutput("t3 err code", {29'd0, lastErrSeen}, 32'd1);
    checkOutput("t3 err_cnt", {16'd0, err_cnt}, 32'd1);
    sendPacket(0, macOf(0), macOf(0), 22'd5, 10'd0, -1, '0, 22'd9, 0, -1, 1'b0);
    sendPacket(2048, macOf(0), macOf(0), 22'd5, 10'd0, -1, '0, 22'd9, 0, -1, 1'b0);
    sendPacket(32, macOf(1), macOf(3), 22'd1000, 10'd0, -1, '0, 22'd1007, 0, -1, 1'b0);
    idle(2);
    @(negedge clk);
    checkOutput("t3 err_cnt after 3 bad", {16'd0, err_cnt}, 32'd3);
    checkOutput("t3 recovery meta", lastMetaSeen, {2'd3, 2'd1, 6'd1, 22'd7});

    $display("[TB] directed: unknown DMAC plus corrupt payload");
    sendPacket(32, BAD_MAC, macOf(1), 22'd0, 10'd0, 6, 32'h0, 22'd3, 0, -1, 1'b0);
    idle(2);
    @(negedge clk);
    checkOutput("t4 err code", {29'd0, lastErrSeen}, 32'd2);
    checkOutput("t4 meta pulses", 32'(metaPulses), 32'd3);

    $display("[TB] directed: payload word FFFFFFFE");
    mBefore = metaPulses; eBefore = errPulses;
    sendPacket(32, macOf(0), macOf(2), 22'd10, 10'd0, 6, 32'hFFFF_FFFE, 22'd20, 0, -1, 1'b0);
    idle(2);
    @(negedge clk);
    checkOutput("t5 outcome", {16'(errPulses - eBefore), 16'(metaPulses - mBefore)},
                PAY_CHECK ? 32'h0001_0000 : 32'h0000_0001);

    $display("[TB] directed: clear coinciding with increment");
    sendPacket(64, macOf(1), macOf(1), 22'd0, 10'd0, -1, '0, 22'd40, 0, -1, 1'b1);
    idle(2);
    @(negedge clk);
    checkOutput("t6 clear wins", {16'd0, pkt_cnt}, 32'd0);

    $display("[TB] directed: back-to-back packets then reset mid-packet");
    mBefore = metaPulses;
    sendPacket(32, macOf(2), macOf(3), 22'd50, 10'd0, -1, '0, 22'd60, 0, -1, 1'b0);
    sendPacket(64, macOf(3), macOf(2), 22'd70, 10'd0, -1, '0, 22'd90, 0, -1, 1'b0);
    sendPacket(64, macOf(0), macOf(1), 22'd70, 10'd0, -1, '0, 22'd90, 0, 4, 1'b0);
    idle(20);
    @(negedge clk);
    checkOutput("t7 meta pulses", 32'(metaPulses - mBefore), 32'd2);
    checkOutput("t7 pkt_cnt after reset", {16'd0, pkt_cnt}, 32'd0);

    $display("[TB] random packets");
    for (int n = 0; n < 40; n++) begin
      blocks = $urandom_range(6, 1);
      len = blocks * 32;
      if ($urandom_range(99, 0) < 10) begin
        case ($urandom_range(3, 0))
          0: len = len + 4;
          1: len = 0;
          2: len = 2048;
          default: len = len + 16;
        endcase
      end
      dm = ($urandom_range(99, 0) < 10) ? {16'hDEAD, 32'($urandom)} : macOf($urandom_range(3, 0));
      sm = ($urandom_range(99, 0) < 10) ? {16'hBEEF, 32'($urandom)} : macOf($urandom_range(3, 0));
      tr = ($urandom_range(99, 0) < 5) ? 10'($urandom_range(1023, 1)) : 10'd0;
      nW = blocks * 8;
      bIdx = ($urandom_range(99, 0) < 15) ? $urandom_range(nW - 1, 6) : -1;
      sendPacket(len, dm, sm, 22'($urandom), tr, bIdx, $urandom, 22'($urandom),
                 $urandom_range(40, 0), -1, ($urandom_range(99, 0) < 10));
      if ($urandom_range(99, 0) < 20) idle($urandom_range(3, 1));
    end
    idle(4);
    @(negedge clk);
    checkOutput("all results delivered", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/packet_check.md
Name: packet_check

Overview:
- Egress-side receiver for the 32-bit block-formatted test packets emitted by packet_gen.
- Consumes one word per valid cycle and parses the header: length, destination MAC, start timestamp, end-time word and source MAC.
- Checks the payload, computes packet latency from a free-running time counter, and emits one 32-bit result record per packet.
- The record uses the same meta layout packet_gen consumes ({src[1:0], dst[1:0], len_blocks[5:0], time[21:0]}), so software reads results in the same format it writes.

Parameters:
- BLOCK_SIZE, 32, bytes per block; a length field must be a multiple of this.
- META_WIDTH, 32, width of the result record.
- CNT_WIDTH, 16, width of the good-packet and error counters.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- packet_in  input  32  incoming packet word
- packet_in_en  input  1  packet_in valid this cycle; idle gaps between words are allowed
- time_now  input  22  free-running time counter, same timebase as the generator's start time
- clear_stats  input  1  synchronous clear of both counters
- meta_out  output  META_WIDTH  {src_port, dst_port, len_blocks, latency}
- meta_out_en  output  1  one-cycle pulse, meta_out valid
- err_en  output  1  one-cycle pulse, err_code valid
- err_code  output  3  1 = bad length, 2 = unknown DMAC, 3 = unknown SMAC, 4 = time word reserved bits set, 5 = payload mismatch
- pkt_cnt  output  CNT_WIDTH  count of good packets
- err_cnt  output  CNT_WIDTH  count of errored packets

Behaviour:
- Reset values: state H_LEN; meta_out = 0; meta_out_en = 0; err_en = 0; err_code = 0; pkt_cnt = 0; err_cnt = 0.
- Word format, in order:
  - w0 = {len_bytes[15:0], DMAC[47:32]}
  - w1 = DMAC[31:0]
  - w2 = {10'b0, start_time[21:0]}
  - w3 = end-time word, ignored
  - w4 = {16'b0, SMAC[47:32]}
  - w5 = SMAC[31:0]
  - payload = all-ones words
- Word count:
  - total words = len_bytes/4; payload words = total − 6.
  - len_blocks = len_bytes[10:5].
- State advance: the FSM advances only on cycles with packet_in_en = 1. States:
  - H_LEN: latch length and DMAC high; go to H_DMAC.
    - If len_bytes[4:0] != 0, or len_bytes == 0, or len_bytes > 63·32: pulse err_en with code 1 next cycle and stay in H_LEN, so the next word is treated as a new w0.
  - H_DMAC → H_TSTART → H_TEND → H_SMAC_HI → H_SMAC_LO → PAYLOAD.
    - In H_SMAC_LO, load the payload counter with payload words − 1.
  - PAYLOAD: decrement the counter per accepted word; when the counter is 0 on an accepted word, the packet ends; go to H_LEN.
- MAC decode:
  - Instantiate four port_to_mac with constant ports 0–3 and compare the full 48-bit value.
  - The first match gives the port; no match records code 2 (DMAC) or 3 (SMAC).
- Error priority: an error is sticky within a packet; the first one recorded wins. Codes 2–5 do not abort the packet, which is consumed to its declared length.
- Latency = (time_now − start_time) mod 2^22, sampled on the cycle the last word is accepted.
- Result output: one cycle after the last word is accepted, exactly one of these occurs:
  - meta_out_en pulses with meta_out updated, and pkt_cnt += 1; or
  - err_en pulses with err_code updated, and err_cnt += 1.
- meta_out holds its value between pulses.
- Counters saturate at all-ones.
- clear_stats zeroes both counters. If it coincides with an increment, the clear wins and the result is 0.
- Back-to-back packets: the w0 of the next packet may arrive on the cycle right after the previous last word, with no bubble required.
- Reset mid-packet discards the partial packet with no pulse; parsing restarts at H_LEN.

Optional Feature:
- Macro: PACKET_CHECK_PAYLOAD_EN.
- Defined: every payload word must equal 32'hFFFF_FFFF; the first mismatch records code 5.
- Undefined: payload words are only counted; code 5 is never produced; no 32-bit comparator is built.

Test Plan:
- 1-block packet, SMAC = port 1, DMAC = port 2, start 100, last word (w7) at time_now 250 → meta_out = {2'd1, 2'd2, 6'd1, 22'd150}, one meta_out_en pulse, pkt_cnt = 1.
- 63-block packet (504 words) with random packet_in_en gaps; start 22'h3FFFF0, end 22'h000010 → latency 22'h20, len_blocks = 63, one pulse only.
- w0 len_bytes = 40 → err_en, code 1, err_cnt = 1; the next valid 1-block packet parses correctly.
- DMAC not matching any port, payload corrupt in word 6 → code 2 (first error wins), pulse after word 7, no meta_out_en.
- With PACKET_CHECK_PAYLOAD_EN, payload word 32'hFFFF_FFFE → code 5; the same stimulus without the macro → good meta_out.
- Two back-to-back packets with no bubble, then reset asserted mid-third packet → two meta pulses, no third pulse, pkt_cnt returns to 0 after reset.
